// File: rtl/high_score_keeper_pkg.sv
// Shared constants and FSM encoding for the end-of-game high score keeper.
package high_score_keeper_pkg;

    localparam int unsigned NUM_PLAYERS = 8;
    localparam int unsigned SCORE_W     = 7;
    localparam int unsigned SCORE_MAX   = 99;
    localparam int unsigned ID_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CMP  = 2'd2,
        ST_RESP = 2'd3
    } hsk_state_t;

endpackage

// File: rtl/hs_regfile.sv
// Personal-best storage: one registered read port, one write port, async clear.
module hs_regfile #(
    parameter int unsigned NUM_PLAYERS = high_score_keeper_pkg::NUM_PLAYERS,
    parameter int unsigned SCORE_W     = high_score_keeper_pkg::SCORE_W,
    parameter int unsigned ID_W        = high_score_keeper_pkg::ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic [ID_W-1:0]    rd_addr,
    output logic [SCORE_W-1:0] rd_data,
    input  logic               we,
    input  logic [ID_W-1:0]    wr_addr,
    input  logic [SCORE_W-1:0] wr_data
);

    logic [SCORE_W-1:0] mem [NUM_PLAYERS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/high_score_keeper.sv
// Scores one end-of-game request against the personal and global bests and
// answers with a single valid pulse plus held win flags.
module high_score_keeper
    import high_score_keeper_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = high_score_keeper_pkg::NUM_PLAYERS,
    parameter int unsigned SCORE_W     = high_score_keeper_pkg::SCORE_W,
    parameter int unsigned SCORE_MAX   = high_score_keeper_pkg::SCORE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_req,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [ID_W-1:0]    player_id,
    input  logic               is_guest,
    output logic               busy,
    output logic               valid,
    output logic               personal_win,
    output logic               global_win,
    output logic [SCORE_W-1:0] global_best
);

    hsk_state_t         state_q, state_d;
    logic               accept_c;
    logic               id_oob_c;
    logic [SCORE_W-1:0] clamped_c;
    logic [SCORE_W-1:0] score_q;
    logic [ID_W-1:0]    id_q;
    logic               guest_q;
    logic [SCORE_W-1:0] table_rd;
    logic               pwin_c, gwin_c;

    // Ids beyond the table can only exist with a shrunk table; they score as guests.
    if (NUM_PLAYERS < (1 << ID_W)) begin : g_oob
        assign id_oob_c = 32'(player_id) >= NUM_PLAYERS;
    end else begin : g_no_oob
        assign id_oob_c = 1'b0;
    end

    assign clamped_c = (score_in > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_in;
    assign pwin_c    = !guest_q && (score_q > table_rd);
    assign gwin_c    = score_q > global_best;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RESP may accept a new request so throughput reaches one per three cycles.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (score_req) begin
                    accept_c = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: state_d = ST_CMP;
            ST_CMP:  state_d = ST_RESP;
            ST_RESP: begin
                if (score_req) begin
                    accept_c = 1'b1;
                    state_d  = ST_READ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= '0;
            id_q    <= '0;
            guest_q <= 1'b0;
        end else if (accept_c) begin
            score_q <= clamped_c;
            id_q    <= player_id;
            guest_q <= is_guest || id_oob_c;
        end
    end

    hs_regfile #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SCORE_W     (SCORE_W),
        .ID_W        (ID_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (state_q == ST_READ),
        .rd_addr (id_q),
        .rd_data (table_rd),
        .we      ((state_q == ST_CMP) && pwin_c),
        .wr_addr (id_q),
        .wr_data (score_q)
    );

    // Flags and the global best commit together when leaving CMP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            valid        <= 1'b0;
            personal_win <= 1'b0;
            global_win   <= 1'b0;
            global_best  <= '0;
        end else begin
            busy  <= (state_d != ST_IDLE);
            valid <= (state_d == ST_RESP);
            if (state_q == ST_CMP) begin
                personal_win <= pwin_c;
                global_win   <= gwin_c;
                if (gwin_c) begin
                    global_best <= score_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_high_score_keeper.sv
// Scoreboard bench: stimulus queues expected responses, a monitor checks each valid.
module tb_high_score_keeper;

    localparam int unsigned SCORE_W = 7;

    typedef struct {
        int pwin;
        int gwin;
        int best;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               score_req = 1'b0;
    logic [SCORE_W-1:0] score_in = '0;
    logic [2:0]         player_id = '0;
    logic               is_guest = 1'b0;
    logic               busy, valid, personal_win, global_win;
    logic [SCORE_W-1:0] global_best;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    high_score_keeper dut (
        .clk          (clk),
        .rst          (rst),
        .score_req    (score_req),
        .score_in     (score_in),
        .player_id    (player_id),
        .is_guest     (is_guest),
        .busy         (busy),
        .valid        (valid),
        .personal_win (personal_win),
        .global_win   (global_win),
        .global_best  (global_best)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1, expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("personal_win", int'(personal_win), e.pwin);
                chk("global_win", int'(global_win), e.gwin);
                chk("global_best", int'(global_best), e.best);
                chk("valid_cycle", cyc, e.cyc);
                chk("busy_at_valid", int'(busy), 1);
            end
        end
    end

    task automatic drive(input int score, input int id, input int guest);
        score_req = 1'b1;
        score_in  = SCORE_W'(score);
        player_id = 3'(id);
        is_guest  = guest[0];
    endtask

    task automatic expect_rsp(input int pw, input int gw, input int best);
        exp_t e;
        e.pwin = pw;
        e.gwin = gw;
        e.best = best;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
    endtask

    // One request, raised for a single cycle; called at a negedge.
    task automatic request(input int score, input int id, input int guest,
                           input int pw, input int gw, input int best);
        drive(score, id, guest);
        expect_rsp(pw, gw, best);
        @(negedge clk);
        score_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL response_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_personal_win"}, int'(personal_win), 0);
        chk({tag, "_global_win"}, int'(global_win), 0);
        chk({tag, "_global_best"}, int'(global_best), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b1;
        @(negedge clk);

        request(15, 2, 0, 1, 1, 15);
        drain();
        request(10, 3, 0, 1, 0, 15);
        drain();
        request(10, 3, 0, 0, 0, 15);
        drain();
        request(40, 2, 1, 0, 1, 40);
        drain();
        request(20, 2, 0, 1, 0, 40);
        drain();

        // Clamp, with a second request one cycle later that must be dropped.
        drive(120, 5, 0);
        expect_rsp(1, 1, 99);
        @(negedge clk);
        drive(90, 6, 0);
        @(negedge clk);
        score_req = 1'b0;
        drain();

        // Reset asserted while the request sits in CMP.
        drive(33, 4, 0);
        @(negedge clk);
        score_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        request(1, 2, 0, 1, 1, 1);
        drain();

        // Back-to-back at E0 and E3; the second sees the first's update.
        request(50, 4, 0, 1, 1, 50);
        repeat (2) @(negedge clk);
        request(50, 4, 0, 0, 0, 50);
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
